// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge blocks.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_e;

  // Peripheral regions, matched against addr[31:26]
  localparam logic [5:0] REGION0 = 6'b100000;
  localparam logic [5:0] REGION1 = 6'b100001;
  localparam logic [5:0] REGION2 = 6'b100010;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: one-hot peripheral select plus a mapped flag.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        sel,
  output logic              mapped
);

  // Only the region field takes part in the decode.
  logic unused_addr;
  assign unused_addr = ^addr[25:0];

  always_comb begin
    sel = 3'b000;
    unique case (addr[31:26])
      REGION0: sel = 3'b001;
      REGION1: sel = 3'b010;
      REGION2: sel = 3'b100;
      default: sel = 3'b000;
    endcase
    mapped = |sel;
  end

endmodule

// File: rtl/apb_xfer_controller.sv
// Sequences one APB transfer at a time (SETUP/ACCESS) and returns a one-cycle response.
module apb_xfer_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        pselx,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef struct packed {
    logic              write;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [2:0] dec_sel;
  logic       dec_mapped;

  apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr   (req_addr),
    .sel    (dec_sel),
    .mapped (dec_mapped)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{write: req_write, sel: dec_sel, addr: req_addr, wdata: req_wdata};
          state_d = dec_mapped ? SETUP : DERR;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          // Errored or write responses carry zero data.
          rsp_rdata_d = (!req_q.write && !pslverr) ? prdata : '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE) && hresetn;
  assign pselx     = (state_q == SETUP || state_q == ACCESS) ? req_q.sel : 3'b000;
  assign penable   = (state_q == ACCESS);
  assign paddr     = req_q.addr;
  assign pwdata    = req_q.wdata;
  assign pwrite    = req_q.write;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_xfer_controller.sv
// Randomized and directed bench for apb_xfer_controller with a transaction-level reference model.
module tb_apb_xfer_controller;

  localparam int TO = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, penable, pready, pslverr;
  logic [2:0]  pselx;

  int tests = 0;
  int fails = 0;

  apb_xfer_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(5)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable), .pselx(pselx),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  // Reference select: region index counted from the first peripheral base.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    int idx;
    idx = int'(a[31:26]) - 32;
    return (idx >= 0 && idx < 3) ? 3'(1 << idx) : 3'b000;
  endfunction

  // Entered at a negedge of an IDLE cycle; returns at the negedge of the response cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input int waits, input bit serr, input logic [31:0] rd, input string nm);
    logic [2:0]  esel;
    int          n, last, acc;
    bit          eerr;
    logic [31:0] erd;
    esel = ref_sel(a);
    if (esel == 3'b000) begin
      last = 2; eerr = 1'b1;
    end else begin
      n    = (waits < TO) ? waits + 1 : TO;
      last = 2 + n;
      eerr = (waits >= TO) || serr;
    end
    erd = (wr || eerr) ? 32'h0 : rd;

    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s accept: req_ready=%b exp 1", nm, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    acc = 0;
    for (int c = 1; c <= last; c++) begin
      @(negedge hclk);
      // Request lines are garbage after accept and must be ignored.
      req_valid = $urandom_range(0, 1); req_write = $urandom_range(0, 1);
      req_addr = $urandom; req_wdata = $urandom;
      pready = 1'b0; pslverr = $urandom_range(0, 1); prdata = $urandom;
      tests++;
      if (c == last) begin
        req_valid = 1'b0;
        pslverr   = 1'b0;
        if ({rsp_valid, rsp_err, rsp_rdata, pselx, penable, req_ready} !==
            {1'b1, eerr, erd, 3'b000, 1'b0, 1'b1}) begin
          fails++;
          $display("FAIL %s rsp: valid=%b err=%b rdata=%h sel=%b en=%b rdy=%b exp 1 %b %h 000 0 1",
                   nm, rsp_valid, rsp_err, rsp_rdata, pselx, penable, req_ready, eerr, erd);
        end
      end else if (esel == 3'b000) begin
        if ({pselx, penable, rsp_valid, req_ready} !== {3'b000, 1'b0, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL %s derr c%0d: sel=%b en=%b rv=%b rdy=%b exp 000 0 0 0",
                   nm, c, pselx, penable, rsp_valid, req_ready);
        end
      end else begin
        if ({pselx, penable, pwrite, paddr, pwdata, rsp_valid, req_ready} !==
            {esel, (c >= 2), wr, a, wd, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL %s c%0d: sel=%b en=%b wr=%b addr=%h wd=%h rv=%b rdy=%b exp %b %b %b %h %h 0 0",
                   nm, c, pselx, penable, pwrite, paddr, pwdata, rsp_valid, req_ready,
                   esel, (c >= 2), wr, a, wd);
        end
        if (c >= 2) begin
          if (acc == waits) begin
            pready = 1'b1; pslverr = serr; prdata = rd;
          end
          acc++;
        end
      end
    end
  endtask

  task automatic test_reset;
    hresetn = 1'b0; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 32'h8000_0000; req_wdata = 32'h1234_5678;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge hclk);
    tests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwdata, pwrite, penable, pselx} !== '0) begin
      fails++;
      $display("FAIL reset: rdy=%b rv=%b err=%b rd=%h addr=%h wd=%h wr=%b en=%b sel=%b exp all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwdata, pwrite, penable, pselx);
    end
    req_valid = 1'b0; pready = 1'b0; pslverr = 1'b0;
    hresetn = 1'b1;
    @(negedge hclk);
    tests++;
    if ({req_ready, pselx, rsp_valid} !== {1'b1, 3'b000, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: rdy=%b sel=%b rv=%b exp 1 000 0", req_ready, pselx, rsp_valid);
    end
  endtask

  task automatic test_write_zero_wait;
    xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "wr_zero_wait");
  endtask

  task automatic test_read_waits;
    @(negedge hclk);
    xfer(1'b0, 32'h8400_0004, 32'h0, 3, 1'b0, 32'h0000_00A5, "rd_wait3");
  endtask

  task automatic test_slverr;
    @(negedge hclk);
    xfer(1'b0, 32'h8800_0000, 32'h0, 0, 1'b1, 32'h5555_AAAA, "rd_slverr");
  endtask

  task automatic test_decode_err;
    @(negedge hclk);
    xfer(1'b0, 32'h1000_0000, 32'h0, 0, 1'b0, 32'h0, "decode_err");
  endtask

  task automatic test_timeout;
    @(negedge hclk);
    xfer(1'b0, 32'h8000_0000, 32'h0, 1000, 1'b0, 32'h0, "timeout");
    // Ready on the last counted cycle still completes normally.
    xfer(1'b0, 32'h8400_0000, 32'h0, TO - 1, 1'b0, 32'hCAFE_0001, "ready_last_cycle");
  endtask

  task automatic test_reset_mid_access;
    @(negedge hclk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000; req_wdata = 32'h0;
    @(negedge hclk);
    req_valid = 1'b0; pready = 1'b0;
    @(negedge hclk);
    tests++;
    if (penable !== 1'b1) begin
      fails++; $display("FAIL rst_mid pre: en=%b exp 1", penable);
    end
    hresetn = 1'b0;
    @(negedge hclk);
    tests++;
    if ({pselx, penable, rsp_valid, req_ready} !== {3'b000, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid: sel=%b en=%b rv=%b rdy=%b exp 000 0 0 0", pselx, penable, rsp_valid, req_ready);
    end
    hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      tests++;
      if ({rsp_valid, req_ready, pselx} !== {1'b0, 1'b1, 3'b000}) begin
        fails++;
        $display("FAIL rst_mid post%0d: rv=%b rdy=%b sel=%b exp 0 1 000", i, rsp_valid, req_ready, pselx);
      end
    end
  endtask

  task automatic test_back_to_back;
    xfer(1'b1, 32'h8400_0100, 32'h0BAD_F00D, 0, 1'b0, 32'h0, "b2b_wr");
    xfer(1'b0, 32'h8800_0200, 32'h0, 0, 1'b0, 32'h1357_9BDF, "b2b_rd");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [5:0]  top;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: top = 6'b100000;
        1: top = 6'b100001;
        2: top = 6'b100010;
        default: begin
          top = 6'($urandom);
          if (top >= 6'b100000 && top <= 6'b100010) top = 6'b000011;
        end
      endcase
      a = {top, 26'($urandom)};
      if ($urandom_range(0, 1) == 0) @(negedge hclk);
      xfer($urandom_range(0, 1), a, $urandom,
           ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 4)),
           $urandom_range(0, 3) == 0, $urandom, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_waits;
    test_slverr;
    test_decode_err;
    test_timeout;
    test_reset_mid_access;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
